axi_lite_bram_slave: RTL and testbench
======================================

Name: axi_lite_bram_slave

Overview:
- AXI4-Lite slave data memory that consumes the core's MMU bus (AR/R/AW/W/B channels, 32-bit data).
- Sits directly downstream of the core, between the core's bus master and an inferred synchronous single-port block RAM.
- Serves one transaction at a time with byte-strobed writes and SLVERR for addresses outside its window.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- MEM_WORDS, 4096, depth in 32-bit words; must be a power of two.

Ports:
- clk  input  1  clock; every flop is clocked on the rising edge.
- rst  input  1  synchronous, active-high reset.
- axi_araddr  input  32  read address.
- axi_arvalid  input  1  read address valid.
- axi_arready  output  1  read address ready.
- axi_rdata  output  32  read data.
- axi_rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- axi_rvalid  output  1  read data valid.
- axi_rready  input  1  read data ready.
- axi_awaddr  input  32  write address.
- axi_awvalid  input  1  write address valid.
- axi_awready  output  1  write address ready.
- axi_wdata  input  32  write data.
- axi_wstrb  input  4  byte enables; bit i covers wdata[8i+7:8i].
- axi_wvalid  input  1  write data valid.
- axi_wready  output  1  write data ready.
- axi_bresp  output  2  write response, same encoding as rresp.
- axi_bvalid  output  1  write response valid.
- axi_bready  input  1  write response ready.

Behaviour:
- Reset state: rvalid, bvalid, rresp, bresp and rdata are 0; FSM in IDLE; all ready outputs are 0 while rst is high.
- Memory contents are not cleared by reset.
- Address decode: offset = addr - BASE_ADDR. Word index = offset[log2(MEM_WORDS)+1:2]; addr[1:0] is ignored.
- In range when offset < 4*MEM_WORDS, computed unsigned, so addresses below BASE_ADDR are out of range.
- FSM states: IDLE, RD_MEM, RD_RESP, WR_COLLECT, WR_RESP.
- IDLE ready outputs: arready = 1. awready = wready = !arvalid, so reads win when AR and AW are valid in the same cycle. Ready outputs may depend combinationally on valid inputs; nothing else may.
- IDLE, AR handshake: latch the address, issue the BRAM read, go to RD_MEM.
- RD_MEM: the BRAM word is registered into rdata (0 if out of range); rresp is set; rvalid = 1 from the next cycle; go to RD_RESP.
- Read latency: AR handshake at cycle T gives rvalid high at T+2.
- RD_RESP: rvalid, rdata and rresp are held stable until rready is sampled high, then go to IDLE. rvalid drops the cycle after the R handshake.
- Minimum spacing between AR handshakes is 3 cycles.
- IDLE with aw and w both handshaking in the same cycle: the write is performed at that edge, go to WR_RESP, bvalid = 1 the next cycle.
- IDLE with only AW or only W handshaking: latch what arrived (address, or data plus strobe), record which arrived, go to WR_COLLECT.
- WR_COLLECT ready outputs: arready = 0. Only the missing channel's ready is 1; the already-received channel's ready is 0.
- WR_COLLECT completion: on the missing handshake the write is performed at that edge, using latched values merged with live ones, then go to WR_RESP.
- Write effect: byte i of the addressed word is updated iff wstrb[i] = 1 and the address is in range. wstrb = 0 gives OKAY with no change.
- Out-of-range write: no memory change; bresp = 2'b10.
- WR_RESP: bvalid and bresp are held until bready; go to IDLE the cycle after the B handshake.
- Only one transaction is outstanding at a time; arready = awready = wready = 0 in RD_MEM, RD_RESP and WR_RESP.
- A read issued the cycle after a write's B handshake returns the new data.
- rst asserted mid-transaction: the FSM goes to IDLE; rvalid and bvalid clear the next edge; latched halves are discarded. A write whose final handshake coincides with the rst edge is not committed.

Test Plan:
- Full write then read at 0x0000_0010: AW+W in the same cycle with wdata 0xDEADBEEF, wstrb 4'hF. Required: bvalid one cycle later with bresp 00. Then AR 0x10 gives rvalid 2 cycles after the handshake, rdata 0xDEADBEEF, rresp 00.
- Byte strobes: word at 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb 4'b0101. Required: read of 0x20 returns 0x11BB33DD.
- Split channels: W presented 3 cycles before AW, and in a second run AW before W. Required: the write commits only after both handshakes, exactly one B response per transaction, and awready/wready go low on the already-received channel.
- Out of range (MEM_WORDS = 4096): write to 0x0000_4000. Required: bresp 10 and no memory change. Read of 0x0000_4000 gives rdata 0, rresp 10.
- Backpressure and collision: AR and AW valid in the same cycle. Required: the read is served first. Hold rready low 5 cycles: rdata and rvalid stay stable and awready stays 0. After the R handshake, the write is accepted from IDLE.
- Reset mid-op: assert rst while in RD_RESP and again while in WR_COLLECT with only AW received. Required: rvalid and bvalid are 0 after the edge, the FSM is in IDLE, and memory is unchanged (a read of the target word returns the old value).

Source files
------------

// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite slave in front of an inferred single-port block RAM.
// It serves one transaction at a time, supports byte-strobed writes and returns
// SLVERR for any address outside the [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) window.
module axi_lite_bram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam int          IDX_W        = $clog2(MEM_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(MEM_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_RESP,
        WR_COLLECT,
        WR_RESP
    } state_t;

    state_t state;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] bram_q;
    logic        rd_in_range;

    logic [31:0] aw_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        have_aw;
    logic        have_w;

    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        wr_commit;
    logic        mem_we;
    logic [31:0] wr_addr_sel;
    logic [31:0] wr_data_sel;
    logic [3:0]  wr_strb_sel;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets,
    // so a single compare rejects both sides of the window.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDR;
        return offset < WINDOW_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // Ready outputs: reads win in IDLE, WR_COLLECT only waits for the missing half.
    always_comb begin
        axi_arready = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    axi_arready = 1'b1;
                    axi_awready = !axi_arvalid;
                    axi_wready  = !axi_arvalid;
                end
                WR_COLLECT: begin
                    axi_awready = !have_aw;
                    axi_wready  = !have_w;
                end
                default: begin
                    axi_arready = 1'b0;
                    axi_awready = 1'b0;
                    axi_wready  = 1'b0;
                end
            endcase
        end
    end

    // Handshakes and the merged write request (latched halves combined with live ones).
    always_comb begin
        ar_hs       = axi_arvalid && axi_arready;
        aw_hs       = axi_awvalid && axi_awready;
        w_hs        = axi_wvalid && axi_wready;
        wr_addr_sel = (state == WR_COLLECT && have_aw) ? aw_addr_q : axi_awaddr;
        wr_data_sel = (state == WR_COLLECT && have_w) ? wdata_q : axi_wdata;
        wr_strb_sel = (state == WR_COLLECT && have_w) ? wstrb_q : axi_wstrb;
        wr_commit   = !rst &&
                      (((state == IDLE) && aw_hs && w_hs) ||
                       ((state == WR_COLLECT) && ((have_aw && w_hs) || (have_w && aw_hs))));
        mem_we      = wr_commit && addr_in_range(wr_addr_sel);
    end

    // Block RAM: byte-enabled write port and registered read, never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_sel[i]) begin
                    mem[addr_index(wr_addr_sel)][8*i +: 8] <= wr_data_sel[8*i +: 8];
                end
            end
        end
        if (ar_hs) begin
            bram_q <= mem[addr_index(axi_araddr)];
        end
    end

    // Transaction FSM with registered R and B channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= 32'h0;
            axi_rresp   <= RESP_OKAY;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            rd_in_range <= 1'b0;
            have_aw     <= 1'b0;
            have_w      <= 1'b0;
            aw_addr_q   <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        rd_in_range <= addr_in_range(axi_araddr);
                        state       <= RD_MEM;
                    end else if (aw_hs && w_hs) begin
                        axi_bresp  <= addr_in_range(axi_awaddr) ? RESP_OKAY : RESP_SLVERR;
                        axi_bvalid <= 1'b1;
                        state      <= WR_RESP;
                    end else if (aw_hs) begin
                        aw_addr_q <= axi_awaddr;
                        have_aw   <= 1'b1;
                        state     <= WR_COLLECT;
                    end else if (w_hs) begin
                        wdata_q <= axi_wdata;
                        wstrb_q <= axi_wstrb;
                        have_w  <= 1'b1;
                        state   <= WR_COLLECT;
                    end
                end
                RD_MEM: begin
                    axi_rdata  <= rd_in_range ? bram_q : 32'h0;
                    axi_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    axi_rvalid <= 1'b1;
                    state      <= RD_RESP;
                end
                RD_RESP: begin
                    if (axi_rready) begin
                        axi_rvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WR_COLLECT: begin
                    if (wr_commit) begin
                        axi_bresp  <= addr_in_range(wr_addr_sel) ? RESP_OKAY : RESP_SLVERR;
                        axi_bvalid <= 1'b1;
                        have_aw    <= 1'b0;
                        have_w     <= 1'b0;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Directed self-checking bench for axi_lite_bram_slave (default parameters:
// BASE_ADDR = 0, MEM_WORDS = 4096, so the window is 0x0000..0x3FFF).
module tb_axi_lite_bram_slave;

    logic        clk;
    logic        rst;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    int vectors;
    int miscompares;

    axi_lite_bram_slave dut (
        .clk         (clk),
        .rst         (rst),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence deadlocks outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full AW+W write in one beat, then collects the B response.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int n;
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        n = 0;
        while (!(axi_awready && axi_wready) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL write_accept_timeout: got no aw/w ready, required ready within 20 cycles");
        end
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        n = 0;
        while (!axi_bvalid && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL write_bvalid_timeout: got bvalid=0, required 1 within 20 cycles");
        end
        resp = axi_bresp;
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
    endtask

    // Single read: AR handshake, wait for R, accept it immediately.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int n;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL read_accept_timeout: got arready=0, required 1 within 20 cycles");
        end
        step();
        axi_arvalid = 1'b0;
        n = 0;
        while (!axi_rvalid && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL read_rvalid_timeout: got rvalid=0, required 1 within 20 cycles");
        end
        data = axi_rdata;
        resp = axi_rresp;
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
    endtask

    // Reset values and ready gating while reset is held.
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({axi_rvalid, axi_bvalid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_valids: got rvalid,bvalid=%b, required 00", {axi_rvalid, axi_bvalid});
        end
        vectors++;
        if ({axi_rresp, axi_bresp} !== 4'b0000 || axi_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_resp_data: got rresp=%b bresp=%b rdata=%h, required 00 00 00000000",
                     axi_rresp, axi_bresp, axi_rdata);
        end
        vectors++;
        if ({axi_arready, axi_awready, axi_wready} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_readies: got ar,aw,w ready=%b, required 000",
                     {axi_arready, axi_awready, axi_wready});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({axi_arready, axi_awready, axi_wready} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL idle_readies: got ar,aw,w ready=%b, required 111",
                     {axi_arready, axi_awready, axi_wready});
        end
    endtask

    // Same-cycle AW+W write at 0x10 followed by a read with cycle-exact latency.
    task automatic test_full_write_read();
        axi_awaddr  = 32'h0000_0010;
        axi_wdata   = 32'hDEAD_BEEF;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        vectors++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL full_write_b: got bvalid=%b bresp=%b, required 1 00", axi_bvalid, axi_bresp);
        end
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        vectors++;
        if (axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_write_b_drop: got bvalid=%b, required 0", axi_bvalid);
        end
        axi_araddr  = 32'h0000_0010;
        axi_arvalid = 1'b1;
        step();
        axi_arvalid = 1'b0;
        vectors++;
        if (axi_rvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_latency_early: got rvalid=%b one cycle after AR, required 0", axi_rvalid);
        end
        step();
        vectors++;
        if (axi_rvalid !== 1'b1 || axi_rdata !== 32'hDEAD_BEEF || axi_rresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL full_read: got rvalid=%b rdata=%h rresp=%b, required 1 deadbeef 00",
                     axi_rvalid, axi_rdata, axi_rresp);
        end
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
        vectors++;
        if (axi_rvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_r_drop: got rvalid=%b, required 0", axi_rvalid);
        end
    endtask

    // Partial-strobe merge and the all-zero strobe case.
    task automatic test_byte_strobes();
        logic [1:0]  resp;
        logic [31:0] data;
        do_write(32'h0000_0020, 32'h1122_3344, 4'hF, resp);
        do_write(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, resp);
        vectors++;
        if (resp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL strobe_bresp: got %b, required 00", resp);
        end
        do_read(32'h0000_0020, data, resp);
        vectors++;
        if (data !== 32'h11BB_33DD || resp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL strobe_merge: got %h/%b, required 11bb33dd/00", data, resp);
        end
        do_write(32'h0000_0020, 32'hFFFF_FFFF, 4'h0, resp);
        vectors++;
        if (resp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL zero_strobe_bresp: got %b, required 00", resp);
        end
        do_read(32'h0000_0020, data, resp);
        vectors++;
        if (data !== 32'h11BB_33DD) begin
            miscompares++;
            $display("[TB] FAIL zero_strobe_nochange: got %h, required 11bb33dd", data);
        end
    endtask

    // W-before-AW and AW-before-W with a three-cycle gap between the halves.
    task automatic test_split_channels();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_wdata  = 32'h1234_5678;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        vectors++;
        if ({axi_arready, axi_awready, axi_wready} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL split_w_first_readies: got ar,aw,w=%b, required 010",
                     {axi_arready, axi_awready, axi_wready});
        end
        step();
        step();
        vectors++;
        if (axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL split_w_first_early_b: got bvalid=%b, required 0", axi_bvalid);
        end
        axi_awaddr  = 32'h0000_0030;
        axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        vectors++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL split_w_first_b: got bvalid=%b bresp=%b, required 1 00", axi_bvalid, axi_bresp);
        end
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        step();
        vectors++;
        if (axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL split_single_b: got bvalid=%b after B handshake, required 0", axi_bvalid);
        end
        do_read(32'h0000_0030, data, resp);
        vectors++;
        if (data !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL split_w_first_data: got %h, required 12345678", data);
        end

        axi_awaddr  = 32'h0000_0034;
        axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        vectors++;
        if ({axi_arready, axi_awready, axi_wready} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL split_aw_first_readies: got ar,aw,w=%b, required 001",
                     {axi_arready, axi_awready, axi_wready});
        end
        step();
        step();
        vectors++;
        if (axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL split_aw_first_early_b: got bvalid=%b, required 0", axi_bvalid);
        end
        axi_wdata  = 32'hCAFE_F00D;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        vectors++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL split_aw_first_b: got bvalid=%b bresp=%b, required 1 00", axi_bvalid, axi_bresp);
        end
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        do_read(32'h0000_0034, data, resp);
        vectors++;
        if (data !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("[TB] FAIL split_aw_first_data: got %h, required cafef00d", data);
        end
    endtask

    // Window edges: last word in range, first word past the end (which would alias word 0).
    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] data;
        do_write(32'h0000_0000, 32'h0102_0304, 4'hF, resp);
        do_write(32'h0000_3FFC, 32'h5A5A_5A5A, 4'hF, resp);
        vectors++;
        if (resp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL last_word_bresp: got %b, required 00", resp);
        end
        do_write(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, resp);
        vectors++;
        if (resp !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL oor_bresp: got %b, required 10", resp);
        end
        do_read(32'h0000_0000, data, resp);
        vectors++;
        if (data !== 32'h0102_0304) begin
            miscompares++;
            $display("[TB] FAIL oor_no_alias_write: got %h, required 01020304", data);
        end
        do_read(32'h0000_4000, data, resp);
        vectors++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL oor_read: got %h/%b, required 00000000/10", data, resp);
        end
        do_read(32'h0000_3FFC, data, resp);
        vectors++;
        if (data !== 32'h5A5A_5A5A || resp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL last_word_read: got %h/%b, required 5a5a5a5a/00", data, resp);
        end
    endtask

    // AR and AW+W together: read first, R held under backpressure, then the write.
    task automatic test_back_to_back();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_araddr  = 32'h0000_0020;
        axi_arvalid = 1'b1;
        axi_awaddr  = 32'h0000_0024;
        axi_wdata   = 32'h0BAD_CAFE;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        #1;
        vectors++;
        if ({axi_arready, axi_awready, axi_wready} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL collision_readies: got ar,aw,w=%b, required 100",
                     {axi_arready, axi_awready, axi_wready});
        end
        step();
        axi_arvalid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h11BB_33DD || axi_awready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold[%0d]: got rvalid=%b rdata=%h awready=%b, required 1 11bb33dd 0",
                         i, axi_rvalid, axi_rdata, axi_awready);
            end
            step();
        end
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
        vectors++;
        if (axi_rvalid !== 1'b0 || axi_awready !== 1'b1 || axi_wready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL after_r_idle: got rvalid=%b awready=%b wready=%b, required 0 1 1",
                     axi_rvalid, axi_awready, axi_wready);
        end
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        vectors++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL collision_write_b: got bvalid=%b bresp=%b, required 1 00", axi_bvalid, axi_bresp);
        end
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        do_read(32'h0000_0024, data, resp);
        vectors++;
        if (data !== 32'h0BAD_CAFE) begin
            miscompares++;
            $display("[TB] FAIL collision_write_data: got %h, required 0badcafe", data);
        end
    endtask

    // Reset during RD_RESP and during WR_COLLECT with only AW received.
    task automatic test_reset_mid_op();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_araddr  = 32'h0000_0020;
        axi_arvalid = 1'b1;
        step();
        axi_arvalid = 1'b0;
        step();
        vectors++;
        if (axi_rvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_read_rvalid: got %b, required 1", axi_rvalid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (axi_rvalid !== 1'b0 || axi_bvalid !== 1'b0 || axi_arready !== 1'b1 || axi_awready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_in_rd_resp: got rvalid=%b bvalid=%b arready=%b awready=%b, required 0 0 1 1",
                     axi_rvalid, axi_bvalid, axi_arready, axi_awready);
        end

        axi_awaddr  = 32'h0000_0020;
        axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        vectors++;
        if (axi_awready !== 1'b0 || axi_wready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_collect_readies: got awready=%b wready=%b, required 0 1", axi_awready, axi_wready);
        end
        rst        = 1'b1;
        axi_wdata  = 32'hFFFF_FFFF;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        step();
        rst        = 1'b0;
        axi_wvalid = 1'b0;
        #1;
        vectors++;
        if (axi_rvalid !== 1'b0 || axi_bvalid !== 1'b0 || axi_arready !== 1'b1 || axi_wready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_in_collect: got rvalid=%b bvalid=%b arready=%b wready=%b, required 0 0 1 1",
                     axi_rvalid, axi_bvalid, axi_arready, axi_wready);
        end
        do_read(32'h0000_0020, data, resp);
        vectors++;
        if (data !== 32'h11BB_33DD || resp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_mem_unchanged: got %h/%b, required 11bb33dd/00", data, resp);
        end
    endtask

    // Scenario sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        axi_araddr  = 32'h0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awaddr  = 32'h0;
        axi_awvalid = 1'b0;
        axi_wdata   = 32'h0;
        axi_wstrb   = 4'h0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        #1;
        test_reset();
        test_full_write_read();
        test_byte_strobes();
        test_split_channels();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
